// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: in-flight rd scoreboard, registered forward selects,
// load-use stall, branch flush and memory freeze. HAZ_PERF_EN adds event counters.
module hazard_fwd_ctrl #(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int ZERO_REG   = 1,
    localparam int SELW      = $clog2(FWD_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_freeze,
    output logic [SELW-1:0]   fwd_sel_a,
    output logic [SELW-1:0]   fwd_sel_b
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
    output logic [31:0]       freeze_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              is_load;
    } entry_t;

    entry_t              sb [0:FWD_STAGES];
    entry_t              id_entry;
    logic [FWD_STAGES:0] hit_a;
    logic [FWD_STAGES:0] hit_b;
    logic [FWD_STAGES:0] late;
    logic                src_ok_a;
    logic                src_ok_b;
    logic                stall_raw;
    logic                stall;
    logic                flush;
    logic                issue;
    logic [SELW-1:0]     sel_a_nx;
    logic [SELW-1:0]     sel_b_nx;

    assign src_ok_a = id_use_rs1 && !((ZERO_REG != 0) && (id_rs1 == '0));
    assign src_ok_b = id_use_rs2 && !((ZERO_REG != 0) && (id_rs2 == '0));

    // A load at e[k] is still in flight when k+1 < 1+LOAD_LAT
    always_comb begin
        hit_a = '0;
        hit_b = '0;
        late  = '0;
        for (int k = 0; k <= FWD_STAGES; k++) begin
            hit_a[k] = sb[k].valid && sb[k].regwrite && src_ok_a
                       && (sb[k].rd == id_rs1);
            hit_b[k] = sb[k].valid && sb[k].regwrite && src_ok_b
                       && (sb[k].rd == id_rs2);
            late[k]  = sb[k].is_load && (k < LOAD_LAT);
        end
    end

    // Walk oldest to youngest so the youngest match wins
    always_comb begin
        sel_a_nx = '0;
        sel_b_nx = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (hit_a[k]) sel_a_nx = SELW'(k + 1);
            if (hit_b[k]) sel_b_nx = SELW'(k + 1);
        end
    end

    assign stall_raw = |((hit_a | hit_b) & late);
    assign flush     = ex_branch_taken && !mem_busy;
    assign stall     = stall_raw && !mem_busy && !ex_branch_taken;
    assign issue     = id_valid && !stall && !ex_branch_taken;

    assign id_entry = '{valid: 1'b1, rd: id_rd,
                        regwrite: id_regwrite, is_load: id_memread};

    assign pipe_freeze = mem_busy;
    assign pc_hold     = rst && (mem_busy || stall);
    assign ifid_hold   = rst && (mem_busy || stall);
    assign ifid_flush  = rst && flush;
    assign idex_bubble = rst && (flush || stall);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= FWD_STAGES; k++) sb[k] <= '0;
            fwd_sel_a <= '0;
            fwd_sel_b <= '0;
        end else if (!mem_busy) begin
            for (int k = FWD_STAGES; k > 0; k--) sb[k] <= sb[k-1];
            sb[0]     <= issue ? id_entry : '0;
            fwd_sel_a <= issue ? sel_a_nx : '0;
            fwd_sel_b <= issue ? sel_b_nx : '0;
        end
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + 32'd1;
            if (mem_busy && freeze_cnt != '1)
                freeze_cnt <= freeze_cnt + 32'd1;
        end
    end
`endif

endmodule
